// File: rtl/fifo_burst_packer.sv
// Packs FWFT FIFO words into length-tagged bursts that never cross a BURST-aligned offset.
// Define FLUSH_TIMEOUT_EN to flush partial bursts after TIMEOUT idle cycles.

module fifo_burst_packer #(
    parameter int NBITS   = 64,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NBITS-1:0]       f_data,
    input  logic                   f_valid,
    output logic                   f_read,
    output logic                   t_req,
    input  logic                   t_ack,
    output logic [$clog2(BURST):0] t_len,
    output logic [31:0]            t_offset,
    output logic [NBITS-1:0]       t_data,
    output logic                   t_valid,
    output logic                   busy
);

    localparam int LW = $clog2(BURST);
    localparam int CW = LW + 1;

    if (NBITS < 1 || NBITS > 72 || BURST < 2 || BURST > 32 ||
        (BURST & (BURST - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("fifo_burst_packer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_REQ,
        S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     len_q, len_d;
    logic [31:0]       offset_q, offset_d;
    logic [NBITS-1:0]  tdat_q, tdat_d;
    logic              tval_q, tval_d;
    logic              treq_q, treq_d;
    logic [NBITS-1:0]  buf_q [BURST];
    logic [CW-1:0]     limit;
    logic [CW-1:0]     n_inc;
`ifdef FLUSH_TIMEOUT_EN
    logic [15:0]       idle_q, idle_d;
`endif

    // Words left before the next BURST-aligned boundary.
    assign limit = CW'(BURST) - {1'b0, offset_q[LW-1:0]};
    assign n_inc = n_q + CW'(1);

    assign f_read = (state_q == S_FILL) & f_valid & enable & (n_q < limit);

    assign t_req    = treq_q;
    assign t_len    = len_q;
    assign t_offset = offset_q;
    assign t_data   = tdat_q;
    assign t_valid  = tval_q;
    assign busy     = (state_q != S_FILL) | (n_q != '0);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        i_d      = i_q;
        len_d    = len_q;
        offset_d = offset_q;
        tdat_d   = tdat_q;
        tval_d   = 1'b0;
`ifdef FLUSH_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        unique case (state_q)
            S_FILL: begin
                if (f_read) begin
                    n_d = n_inc;
`ifdef FLUSH_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (n_inc == limit) begin
                        state_d = S_REQ;
                        len_d   = n_inc;
                    end
                end else if (!enable && n_q != '0) begin
                    state_d = S_REQ;
                    len_d   = n_q;
                end
`ifdef FLUSH_TIMEOUT_EN
                else if (n_q != '0) begin
                    idle_d = idle_q + 16'd1;
                    if (idle_d == 16'(TIMEOUT)) begin
                        state_d = S_REQ;
                        len_d   = n_q;
                        idle_d  = '0;
                    end
                end
`endif
            end
            S_REQ: begin
                if (t_ack) begin
                    state_d = S_SEND;
                    tval_d  = 1'b1;
                    tdat_d  = buf_q[0];
                    i_d     = CW'(1);
                end
            end
            S_SEND: begin
                if (i_q == len_q) begin
                    state_d  = S_FILL;
                    offset_d = offset_q + 32'(len_q);
                    n_d      = '0;
`ifdef FLUSH_TIMEOUT_EN
                    idle_d   = '0;
`endif
                end else begin
                    tval_d = 1'b1;
                    tdat_d = buf_q[i_q[LW-1:0]];
                    i_d    = i_q + CW'(1);
                end
            end
            default: state_d = S_FILL;
        endcase
        treq_d = (state_d == S_REQ);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FILL;
            n_q      <= '0;
            i_q      <= '0;
            len_q    <= '0;
            offset_q <= '0;
            tdat_q   <= '0;
            tval_q   <= 1'b0;
            treq_q   <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            i_q      <= i_d;
            len_q    <= len_d;
            offset_q <= offset_d;
            tdat_q   <= tdat_d;
            tval_q   <= tval_d;
            treq_q   <= treq_d;
`ifdef FLUSH_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    // Buffer contents need no reset: n gates what is ever sent.
    always_ff @(posedge clock) begin
        if (!reset && f_read) begin
            buf_q[n_q[LW-1:0]] <= f_data;
        end
    end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed bench for fifo_burst_packer (BURST=16, TIMEOUT=10).
// The idle-flush scenario runs when FLUSH_TIMEOUT_EN is defined, otherwise the no-flush one.

module tb_fifo_burst_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] f_data;
    logic        f_valid;
    logic        f_read;
    logic        t_req;
    logic        t_ack = 1'b0;
    logic [4:0]  t_len;
    logic [31:0] t_offset;
    logic [63:0] t_data;
    logic        t_valid;
    logic        busy;

    int          vec = 0;
    int          errs = 0;
    int          ptr = 0;
    int          avail = 0;
    logic [7:0]  gen = 8'd0;
    logic [63:0] got [512];
    int          gcnt = 0;

    always #5 clock = ~clock;

    fifo_burst_packer #(.NBITS(64), .BURST(16), .TIMEOUT(10)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .f_data(f_data), .f_valid(f_valid), .f_read(f_read),
        .t_req(t_req), .t_ack(t_ack), .t_len(t_len), .t_offset(t_offset),
        .t_data(t_data), .t_valid(t_valid), .busy(busy)
    );

    // FIFO model: word k of generation g is {g, 24'h0, k}.
    assign f_valid = (ptr < avail);
    assign f_data  = {gen, 24'h0, 32'(ptr)};

    always @(posedge clock) begin
        if (reset) ptr <= 0;
        else if (f_read) ptr <= ptr + 1;
    end

    always @(negedge clock) begin
        if (t_valid && gcnt < 512) begin
            got[gcnt] <= t_data;
            gcnt <= gcnt + 1;
        end
    end

    task automatic do_reset;
        enable = 1'b0;
        t_ack = 1'b0;
        avail = 0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_req(input int max, output int w);
        w = -1;
        for (int c = 0; c < max; c++) begin
            @(negedge clock);
            if (t_req) begin
                w = c;
                break;
            end
        end
    endtask

    task automatic ack_once;
        @(negedge clock);
        t_ack = 1'b1;
        @(negedge clock);
        t_ack = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vec++; if (t_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", t_req); end
        vec++; if (t_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", t_valid); end
        vec++; if (t_len !== 5'd0) begin errs++; $display("FAIL rst_len: got %0d want 0", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL rst_offset: got %h want 0", t_offset); end
        vec++; if (t_data !== 64'd0) begin errs++; $display("FAIL rst_data: got %h want 0", t_data); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec++; if (f_read !== 1'b0) begin errs++; $display("FAIL rst_fread: got %b want 0", f_read); end
    endtask

    task automatic test_back_to_back;
        int w;
        int g0;
        int bad;
        do_reset();
        g0 = gcnt;
        gen = 8'd1;
        avail = 32;
        enable = 1'b1;
        wait_req(100, w);
        vec++; if (w < 0) begin errs++; $display("FAIL b2b_req1: no request, want one"); end
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL b2b_len1: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL b2b_off1: got %h want 0", t_offset); end
        ack_once();
        vec++; if (t_valid !== 1'b1) begin errs++; $display("FAIL b2b_first_valid: got %b want 1", t_valid); end
        vec++; if (t_req !== 1'b0) begin errs++; $display("FAIL b2b_req_drop: got %b want 0", t_req); end
        wait_req(100, w);
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL b2b_len2: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'd16) begin errs++; $display("FAIL b2b_off2: got %h want 16", t_offset); end
        ack_once();
        repeat (20) @(negedge clock);
        vec++; if (gcnt - g0 !== 32) begin errs++; $display("FAIL b2b_count: got %0d want 32", gcnt - g0); end
        bad = 0;
        for (int j = 0; j < 32; j++)
            if (got[g0 + j] !== {8'd1, 24'h0, 32'(j)}) bad++;
        vec++; if (bad != 0) begin errs++; $display("FAIL b2b_data: bad words %0d want 0", bad); end
    endtask

`ifdef FLUSH_TIMEOUT_EN
    task automatic test_timeout;
        int last;
        int req;
        int g0;
        int bad;
        int w;
        do_reset();
        g0 = gcnt;
        gen = 8'd2;
        avail = 5;
        enable = 1'b1;
        last = -1;
        req = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (f_read) last = c;
            if (t_req) begin
                req = c;
                break;
            end
        end
        vec++; if (req - last !== 11) begin errs++; $display("FAIL to_delay: got %0d want 11", req - last); end
        vec++; if (t_len !== 5'd5) begin errs++; $display("FAIL to_len: got %0d want 5", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL to_off: got %h want 0", t_offset); end
        ack_once();
        avail = 32;
        wait_req(100, w);
        vec++; if (t_len !== 5'd11) begin errs++; $display("FAIL to_len2: got %0d want 11", t_len); end
        vec++; if (t_offset !== 32'd5) begin errs++; $display("FAIL to_off2: got %h want 5", t_offset); end
        ack_once();
        wait_req(100, w);
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL to_len3: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'd16) begin errs++; $display("FAIL to_off3: got %h want 16", t_offset); end
        ack_once();
        repeat (20) @(negedge clock);
        bad = 0;
        for (int j = 0; j < 32; j++)
            if (got[g0 + j] !== {8'd2, 24'h0, 32'(j)}) bad++;
        vec++; if (bad != 0) begin errs++; $display("FAIL to_data: bad words %0d want 0", bad); end
    endtask
`else
    task automatic test_no_timeout;
        int reqs;
        int g0;
        int bad;
        int w;
        do_reset();
        g0 = gcnt;
        gen = 8'd4;
        avail = 5;
        enable = 1'b1;
        reqs = 0;
        repeat (1000) begin
            @(negedge clock);
            if (t_req) reqs++;
        end
        vec++; if (reqs != 0) begin errs++; $display("FAIL nt_noreq: got %0d req cycles want 0", reqs); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL nt_busy: got %b want 1", busy); end
        enable = 1'b0;
        @(negedge clock);
        vec++; if (t_req !== 1'b1) begin errs++; $display("FAIL nt_req: got %b want 1", t_req); end
        vec++; if (t_len !== 5'd5) begin errs++; $display("FAIL nt_len: got %0d want 5", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL nt_off: got %h want 0", t_offset); end
        enable = 1'b1;
        avail = 16;
        ack_once();
        wait_req(100, w);
        vec++; if (t_len !== 5'd11) begin errs++; $display("FAIL nt_len2: got %0d want 11", t_len); end
        vec++; if (t_offset !== 32'd5) begin errs++; $display("FAIL nt_off2: got %h want 5", t_offset); end
        ack_once();
        repeat (20) @(negedge clock);
        bad = 0;
        for (int j = 0; j < 16; j++)
            if (got[g0 + j] !== {8'd4, 24'h0, 32'(j)}) bad++;
        vec++; if (bad != 0) begin errs++; $display("FAIL nt_data: bad words %0d want 0", bad); end
    endtask
`endif

    task automatic test_wrap;
        int w;
        int g0;
        int bad;
        do_reset();
        force dut.offset_q = 32'hFFFF_FFF0;
        @(negedge clock);
        release dut.offset_q;
        @(negedge clock);
        vec++; if (t_offset !== 32'hFFFF_FFF0) begin errs++; $display("FAIL wr_load: got %h want fffffff0", t_offset); end
        g0 = gcnt;
        gen = 8'd7;
        avail = 32;
        enable = 1'b1;
        wait_req(100, w);
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL wr_len1: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'hFFFF_FFF0) begin errs++; $display("FAIL wr_off1: got %h want fffffff0", t_offset); end
        ack_once();
        wait_req(100, w);
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL wr_len2: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL wr_off2: got %h want 0", t_offset); end
        ack_once();
        repeat (20) @(negedge clock);
        bad = 0;
        for (int j = 0; j < 32; j++)
            if (got[g0 + j] !== {8'd7, 24'h0, 32'(j)}) bad++;
        vec++; if (bad != 0) begin errs++; $display("FAIL wr_data: bad words %0d want 0", bad); end
    endtask

    task automatic test_hold_ack;
        int w;
        int frozen;
        int g0;
        do_reset();
        gen = 8'd3;
        avail = 1000;
        enable = 1'b1;
        wait_req(100, w);
        frozen = 0;
        repeat (50) begin
            @(negedge clock);
            if (f_read !== 1'b0 || t_req !== 1'b1 || t_len !== 5'd16 || t_offset !== 32'd0)
                frozen++;
        end
        vec++; if (frozen != 0) begin errs++; $display("FAIL hold_stable: bad cycles %0d want 0", frozen); end
        g0 = gcnt;
        ack_once();
        vec++; if (t_valid !== 1'b1) begin errs++; $display("FAIL hold_first: got %b want 1", t_valid); end
        repeat (15) @(negedge clock);
        vec++; if (t_valid !== 1'b1) begin errs++; $display("FAIL hold_last: got %b want 1", t_valid); end
        @(negedge clock);
        vec++; if (t_valid !== 1'b0) begin errs++; $display("FAIL hold_end: got %b want 0", t_valid); end
        repeat (30) @(negedge clock);
        vec++; if (gcnt - g0 !== 16) begin errs++; $display("FAIL hold_count: got %0d want 16", gcnt - g0); end
    endtask

    task automatic test_reset_in_send;
        int w;
        int k;
        int g0;
        int bad;
        do_reset();
        gen = 8'd8;
        avail = 16;
        enable = 1'b1;
        wait_req(100, w);
        ack_once();
        k = 1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clock);
            if (t_valid) k++;
        end
        reset = 1'b1;
        @(negedge clock);
        vec++; if (t_valid !== 1'b0) begin errs++; $display("FAIL rs_valid: got %b want 0", t_valid); end
        vec++; if (t_req !== 1'b0) begin errs++; $display("FAIL rs_req: got %b want 0", t_req); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rs_busy: got %b want 0", busy); end
        reset = 1'b0;
        gen = 8'd9;
        avail = 16;
        wait_req(100, w);
        vec++; if (t_len !== 5'd16) begin errs++; $display("FAIL rs_len: got %0d want 16", t_len); end
        vec++; if (t_offset !== 32'd0) begin errs++; $display("FAIL rs_off: got %h want 0", t_offset); end
        g0 = gcnt;
        ack_once();
        repeat (20) @(negedge clock);
        bad = 0;
        for (int j = 0; j < 16; j++)
            if (got[g0 + j] !== {8'd9, 24'h0, 32'(j)}) bad++;
        vec++; if (bad != 0) begin errs++; $display("FAIL rs_data: bad words %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
`ifdef FLUSH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_wrap();
        test_hold_ack();
        test_reset_in_send();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
